shift_history_buffer: RTL
=========================

Name: shift_history_buffer

Overview:
Parametrised, synchronously clocked shift-history memory. Each accepted push shifts every entry one slot deeper and inserts the new word at slot 0.
Adds the following over the fixed 8x4 write-strobed version:
- Two independently addressable read taps.
- Fill count, full flag and per-tap valid flags.
- Synchronous clear.
- Optional rising-edge push qualification, for strobes that arrive as levels (button/FSM outputs).
Sits between game/control FSMs and display logic as the "last N values" store.

Parameters:
WIDTH, 4, bits per entry (>=1)
DEPTH, 8, number of entries (>=2)
EDGE_MODE, 0, 0 = push is a per-cycle enable; 1 = push accepted only on its 0->1 transition
Derived localparams: SEL_W = $clog2(DEPTH); CNT_W = $clog2(DEPTH+1)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
clear  input  1  synchronous clear of entries and count
push  input  1  write request (level or strobe per EDGE_MODE)
data_in  input  WIDTH  word inserted at slot 0
tap_sel_a  input  SEL_W  slot index for read port A (0 = newest)
tap_sel_b  input  SEL_W  slot index for read port B
data_out_a  output  WIDTH  entry[tap_sel_a]
data_out_b  output  WIDTH  entry[tap_sel_b]
valid_a  output  1  tap_sel_a < count
valid_b  output  1  tap_sel_b < count
oldest  output  WIDTH  entry[DEPTH-1], fixed tap
count  output  CNT_W  number of words written since reset/clear, saturates at DEPTH
full  output  1  count == DEPTH

Behaviour:
- reset (async, any time, including mid-push): all entries = 0, count = 0, push_prev = 0. Outputs then read 0; valid_* = 0; full = 0.
- Effective push (accept):
  - EDGE_MODE=0: accept = push.
  - EDGE_MODE=1: accept = push & ~push_prev. push_prev <= push every cycle, including cycles with clear active.
- Priority per edge: reset > clear > accept.
- clear: all entries <= 0, count <= 0. A push in the same cycle is dropped. In EDGE_MODE=1 its edge is consumed: no accept next cycle even if push is held.
- accept: entry[i] <= entry[i-1] for i = DEPTH-1..1; entry[0] <= data_in. count <= count+1 if count < DEPTH, else unchanged.
- Full condition: pushes continue to accept when full. entry[DEPTH-1] is discarded, count stays DEPTH. No overflow flag.
- Latency: one cycle. A word pushed at edge k is visible on a tap selecting 0 immediately after edge k.
- Read taps are combinational from registered storage; no read latency.
- Out-of-range tap_sel (>= DEPTH, possible when DEPTH is not a power of 2): data_out = 0, valid = 0.
- Both taps may select the same slot; both return identical data.
- No accept: storage and count hold.
- WIDTH/DEPTH arithmetic: count compare uses CNT_W-bit unsigned. Tap-vs-count compare zero-extends tap_sel to CNT_W.
- No X on outputs after reset for any input combination.

Decomposition:
- No shared package; SEL_W/CNT_W are local derived localparams.
- One natural sub-module: push_edge_detect.
  - Ports: clock, reset, level_in, pulse_out.
  - Registered previous level, reset 0.
  - Instantiated only when EDGE_MODE=1, via generate; otherwise pulse_out = push.
- Storage is a single reg array [DEPTH-1:0] of WIDTH bits in the top module.

Test Plan:
1. WIDTH=4, DEPTH=8, EDGE_MODE=0: reset, push 1..8 on consecutive cycles -> count 0->8, full=1 after 8th; tap_sel_a=0 reads 8, tap_sel_b=7 reads 1, oldest=1.
2. Continue from 1, push 9 and A -> count stays 8, full=1, tap 0 = A, oldest = 3; values 1 and 2 gone.
3. After 3 pushes (5,6,7): tap_sel_a=2 -> data 5, valid_a=1; tap_sel_b=3 -> data 0, valid_b=0.
4. Full buffer, assert clear and push (data F) same cycle -> next cycle count=0, all taps 0, valid_*=0, F not stored.
5. EDGE_MODE=1: hold push high 5 cycles with data_in=3 -> exactly one accept (count=1, tap0=3). Drop push 1 cycle, raise again with data 4 -> count=2, tap0=4, tap1=3.
6. Assert reset asynchronously between clock edges while pushing with count=5 -> outputs/count 0 immediately. After release, first accepted push gives count=1; in EDGE_MODE=1 a held-high push is accepted once after release.

Source files
------------

// File: rtl/shift_history_buffer_push_edge_detect.sv
// Rising-edge qualifier for level-style push requests: one pulse per 0->1
// transition of level_in, timed by the registered previous level.
module push_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic level_in,
  output logic pulse_out
);

  logic level_prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) level_prev <= 1'b0;
    else       level_prev <= level_in;
  end

  assign pulse_out = level_in & ~level_prev;

endmodule

// File: rtl/shift_history_buffer.sv
// "Last N values" store: each accepted push shifts history one slot deeper and
// inserts data_in at slot 0. Two combinational read taps plus a fixed oldest tap.
module shift_history_buffer #(
  parameter  int WIDTH     = 4,
  parameter  int DEPTH     = 8,
  parameter  int EDGE_MODE = 0,
  localparam int SEL_W     = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0] tap_sel_a,
  input  logic [SEL_W-1:0] tap_sel_b,
  output logic [WIDTH-1:0] data_out_a,
  output logic [WIDTH-1:0] data_out_b,
  output logic             valid_a,
  output logic             valid_b,
  output logic [WIDTH-1:0] oldest,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [SEL_W:0]   DEPTH_SEL = (SEL_W + 1)'(DEPTH);

  logic [WIDTH-1:0] entries [DEPTH-1:0];
  logic             accept;

  generate
    if (EDGE_MODE == 1) begin : g_edge
      push_edge_detect u_push_edge_detect (
        .clock     (clock),
        .reset     (reset),
        .level_in  (push),
        .pulse_out (accept)
      );
    end else begin : g_level
      assign accept = push;
    end
  endgenerate

  // clear outranks accept; a push arriving alongside clear is dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      count <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      count <= '0;
    end else if (accept) begin
      for (int i = DEPTH - 1; i > 0; i--) entries[i] <= entries[i-1];
      entries[0] <= data_in;
      if (count < DEPTH_CNT) count <= count + CNT_W'(1);
    end
  end

  // Taps past the end of storage (DEPTH not a power of two) read as empty.
  always_comb begin
    data_out_a = '0;
    data_out_b = '0;
    if ({1'b0, tap_sel_a} < DEPTH_SEL) data_out_a = entries[tap_sel_a];
    if ({1'b0, tap_sel_b} < DEPTH_SEL) data_out_b = entries[tap_sel_b];
  end

  assign valid_a = CNT_W'(tap_sel_a) < count;
  assign valid_b = CNT_W'(tap_sel_b) < count;
  assign oldest  = entries[DEPTH-1];
  assign full    = (count == DEPTH_CNT);

endmodule
